// File: rtl/piton_dcr_pkg.sv
// Shared widths, default sizing and the entry record for the multi-source
// DCR write queue.
package piton_dcr_pkg;

  localparam int DCR_ADDR_W = 8;
  localparam int DCR_DATA_W = 32;
  localparam int DCR_DEPTH  = 8;

  // Pointer and occupancy widths for the default queue depth
  localparam int PTR_W = $clog2(DCR_DEPTH);
  localparam int CNT_W = $clog2(DCR_DEPTH + 1);

  typedef struct packed {
    logic [DCR_ADDR_W-1:0] addr;
    logic [DCR_DATA_W-1:0] data;
  } dcr_wr_t;

  // Width of a source index; a single source still needs one bit
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piton_dcr_rr_arb.sv
// Round-robin arbiter: searches upward from rr_ptr with wrap and returns a
// one-hot grant, the granted index and the pointer to use after this cycle.
module piton_dcr_rr_arb
  import piton_dcr_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int RR_W    = rr_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [RR_W-1:0]    rr_ptr,
  input  logic               advance,
  output logic [NUM_SRC-1:0] grant,
  output logic [RR_W-1:0]    grant_idx,
  output logic [RR_W-1:0]    next_ptr
);

  // First valid source at or above rr_ptr, wrapping around
  always_comb begin
    logic found_s;
    int   cand_s;
    grant     = '0;
    grant_idx = rr_ptr;
    found_s   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_s = int'(rr_ptr) + k;
      if (cand_s >= NUM_SRC) begin
        cand_s = cand_s - NUM_SRC;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && valid[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = RR_W'(cand_s);
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the winner only when its request is accepted
  always_comb begin
    if (advance) begin
      if (int'(grant_idx) == NUM_SRC - 1) begin
        next_ptr = '0;
      end else begin
        next_ptr = grant_idx + RR_W'(1);
      end
    end else begin
      next_ptr = rr_ptr;
    end
  end

endmodule

// File: rtl/piton_dcr_wr_queue.sv
// Multi-source DCR write queue: round-robin intake into a FIFO, one write per
// cycle toward the Vortex DCR path, optional hold while Vortex is busy,
// occupancy reporting, synchronous flush and a sticky illegal-address flag.
module piton_dcr_wr_queue
  import piton_dcr_pkg::*;
#(
  parameter int                NUM_SRC      = 2,
  parameter int                DEPTH        = DCR_DEPTH,
  parameter int                ADDR_W       = DCR_ADDR_W,
  parameter int                DATA_W       = DCR_DATA_W,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT   = ADDR_W'(8'hFF),
  parameter bit                HOLD_ON_BUSY = 1'b1,
  localparam int               QPTR_W       = $clog2(DEPTH),
  localparam int               QCNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_wr_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] src_wr_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_wr_data,
  output logic [NUM_SRC-1:0]        src_wr_rdy,
  output logic                      dcr_wr_valid,
  output logic [ADDR_W-1:0]         dcr_wr_addr,
  output logic [DATA_W-1:0]         dcr_wr_data,
  input  logic                      dcr_wr_rdy,
  input  logic                      vx_busy,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic [QCNT_W-1:0]         occupancy,
  output logic                      full,
  output logic                      empty,
  output logic                      addr_err
);

  localparam int RR_W = rr_width(NUM_SRC);

  logic [ADDR_W-1:0] mem_addr_r [DEPTH];
  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [QPTR_W-1:0] wr_ptr_r;
  logic [QPTR_W-1:0] rd_ptr_r;
  logic [QCNT_W-1:0] occ_r;
  logic [RR_W-1:0]   rr_ptr_r;
  logic              addr_err_r;

  logic [NUM_SRC-1:0] grant_s;
  logic [RR_W-1:0]    grant_idx_s;
  logic [RR_W-1:0]    next_rr_s;
  logic [ADDR_W-1:0]  grant_addr_s;
  logic [DATA_W-1:0]  grant_data_s;
  logic               legal_s;
  logic               push_s;
  logic               legal_push_s;
  logic               bad_push_s;
  logic               pop_s;
  logic               hold_s;

  piton_dcr_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .RR_W    (RR_W)
  ) u_arb (
    .valid     (src_wr_valid),
    .rr_ptr    (rr_ptr_r),
    .advance   (push_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .next_ptr  (next_rr_s)
  );

  assign full  = (occ_r == QCNT_W'(DEPTH));
  assign empty = (occ_r == '0);
  assign occupancy = occ_r;
  assign addr_err  = addr_err_r;

  assign hold_s       = HOLD_ON_BUSY && vx_busy;
  assign dcr_wr_valid = !empty && !hold_s;
  assign dcr_wr_addr  = mem_addr_r[rd_ptr_r];
  assign dcr_wr_data  = mem_data_r[rd_ptr_r];

  // Flush cancels a pop so the head is not consumed while being cleared
  assign pop_s = dcr_wr_valid && dcr_wr_rdy && !flush;

  // A full queue may still accept when the head leaves in the same cycle
  assign src_wr_rdy = grant_s & {NUM_SRC{(!full || pop_s) && !flush}};
  assign push_s     = |(src_wr_valid & src_wr_rdy);

  assign grant_addr_s = src_wr_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
  assign grant_data_s = src_wr_data[int'(grant_idx_s)*DATA_W +: DATA_W];
  assign legal_s      = (grant_addr_s < ADDR_LIMIT);
  assign legal_push_s = push_s && legal_s;
  assign bad_push_s   = push_s && !legal_s;

  // Entry storage; illegal writes are handshaken but never stored
  always_ff @(posedge clk) begin
    if (legal_push_s) begin
      mem_addr_r[wr_ptr_r] <= grant_addr_s;
      mem_data_r[wr_ptr_r] <= grant_data_s;
    end
  end

  // Pointers and occupancy; flush clears them, pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      if (legal_push_s) begin
        wr_ptr_r <= wr_ptr_r + QPTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + QPTR_W'(1);
      end
      occ_r <= occ_r + QCNT_W'(legal_push_s) - QCNT_W'(pop_s);
    end
  end

  // Round-robin pointer survives flush; it only moves on an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else begin
      rr_ptr_r <= next_rr_s;
    end
  end

  // Sticky address error; a new error outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_r <= 1'b0;
    end else if (bad_push_s) begin
      addr_err_r <= 1'b1;
    end else if (err_clr) begin
      addr_err_r <= 1'b0;
    end else begin
      addr_err_r <= addr_err_r;
    end
  end

endmodule

// File: tb/tb_piton_dcr_wr_queue.sv
// Directed bench for piton_dcr_wr_queue with NUM_SRC=2, DEPTH=8,
// ADDR_LIMIT=0x10 and HOLD_ON_BUSY=1.
module tb_piton_dcr_wr_queue;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_wr_valid;
  logic [NUM_SRC*ADDR_W-1:0] src_wr_addr;
  logic [NUM_SRC*DATA_W-1:0] src_wr_data;
  logic [NUM_SRC-1:0]        src_wr_rdy;
  logic                      dcr_wr_valid;
  logic [ADDR_W-1:0]         dcr_wr_addr;
  logic [DATA_W-1:0]         dcr_wr_data;
  logic                      dcr_wr_rdy;
  logic                      vx_busy;
  logic                      flush;
  logic                      err_clr;
  logic [CNT_W-1:0]          occupancy;
  logic                      full;
  logic                      empty;
  logic                      addr_err;

  int checks = 0;
  int errors = 0;

  piton_dcr_wr_queue #(
    .NUM_SRC      (NUM_SRC),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .ADDR_LIMIT   (8'h10),
    .HOLD_ON_BUSY (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_wr_valid (src_wr_valid),
    .src_wr_addr  (src_wr_addr),
    .src_wr_data  (src_wr_data),
    .src_wr_rdy   (src_wr_rdy),
    .dcr_wr_valid (dcr_wr_valid),
    .dcr_wr_addr  (dcr_wr_addr),
    .dcr_wr_data  (dcr_wr_data),
    .dcr_wr_rdy   (dcr_wr_rdy),
    .vx_busy      (vx_busy),
    .flush        (flush),
    .err_clr      (err_clr),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [7:0] a, input logic [31:0] d);
    src_wr_addr[s*ADDR_W +: ADDR_W] = a;
    src_wr_data[s*DATA_W +: DATA_W] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_wr_valid = 2'b00; src_wr_addr = '0; src_wr_data = '0;
    dcr_wr_rdy = 1'b0; vx_busy = 1'b0; flush = 1'b0; err_clr = 1'b0;
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (dcr_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dcr_wr_valid); end
    checks++; if (src_wr_rdy !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b exp 00", src_wr_rdy); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", addr_err); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_src(0, 8'h04, 32'hDEADBEEF);
    src_wr_valid = 2'b01;
    #1;
    checks++; if (src_wr_rdy !== 2'b01) begin errors++; $display("FAIL single_rdy got %b exp 01", src_wr_rdy); end
    tick();
    src_wr_valid = 2'b00;
    #1;
    checks++; if (dcr_wr_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", dcr_wr_valid); end
    checks++; if (dcr_wr_addr !== 8'h04) begin errors++; $display("FAIL single_addr got %h exp 04", dcr_wr_addr); end
    checks++; if (dcr_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", dcr_wr_data); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
    dcr_wr_rdy = 1'b1;
    tick();
    dcr_wr_rdy = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL single_occ0 got %0d exp 0", occupancy); end
    checks++; if (dcr_wr_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", dcr_wr_valid); end
  endtask

  // rr pointer sits at 1 after the single src0 write, so src1 wins first
  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_d [4];
    dcr_wr_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        set_src(0, 8'h01, 32'h100 + i);
        set_src(1, 8'h02, 32'h200 + i);
        src_wr_valid = 2'b11;
        exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
        exp_d[i] = (i % 2 == 0) ? 32'h200 + i : 32'h100 + i;
      end else begin
        src_wr_valid = 2'b00;
        exp_g = 2'b00;
      end
      #1;
      checks++; if (src_wr_rdy !== exp_g) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", i, src_wr_rdy, exp_g); end
      if (i >= 1) begin
        checks++; if (dcr_wr_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d got %b exp 1", i, dcr_wr_valid); end
        checks++; if (dcr_wr_data !== exp_d[i-1]) begin errors++; $display("FAIL rr_data%0d got %h exp %h", i, dcr_wr_data, exp_d[i-1]); end
      end
      tick();
    end
    dcr_wr_rdy = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rr_empty got %b exp 1", empty); end
  endtask

  task automatic test_full();
    src_wr_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      set_src(0, 8'h08, 32'h300 + i);
      tick();
    end
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got %0d exp 8", occupancy); end
    checks++; if (src_wr_rdy !== 2'b00) begin errors++; $display("FAIL full_rdy got %b exp 00", src_wr_rdy); end
    set_src(0, 8'h08, 32'h3AA);
    dcr_wr_rdy = 1'b1;
    #1;
    checks++; if (src_wr_rdy !== 2'b01) begin errors++; $display("FAIL full_pushpop_rdy got %b exp 01", src_wr_rdy); end
    checks++; if (dcr_wr_data !== 32'h300) begin errors++; $display("FAIL full_head got %h exp 300", dcr_wr_data); end
    tick();
    src_wr_valid = 2'b00;
    dcr_wr_rdy = 1'b0;
    #1;
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ_keep got %0d exp 8", occupancy); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_keep got %b exp 1", full); end
    dcr_wr_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (dcr_wr_data !== ((i < 7) ? 32'h301 + i : 32'h3AA)) begin
        errors++; $display("FAIL full_drain%0d got %h", i, dcr_wr_data);
      end
      tick();
    end
    dcr_wr_rdy = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b exp 1", empty); end
  endtask

  task automatic test_busy_hold();
    vx_busy = 1'b1;
    src_wr_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      set_src(0, 8'h0A, 32'h400 + i);
      tick();
    end
    src_wr_valid = 2'b00;
    dcr_wr_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (dcr_wr_valid !== 1'b0) begin errors++; $display("FAIL busy_valid%0d got %b exp 0", i, dcr_wr_valid); end
      checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL busy_occ%0d got %0d exp 3", i, occupancy); end
      tick();
    end
    vx_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dcr_wr_valid !== 1'b1) begin errors++; $display("FAIL busy_drain_valid%0d got %b exp 1", i, dcr_wr_valid); end
      checks++; if (dcr_wr_data !== 32'h400 + i) begin errors++; $display("FAIL busy_drain_data%0d got %h exp %h", i, dcr_wr_data, 32'h400 + i); end
      tick();
    end
    dcr_wr_rdy = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL busy_empty got %b exp 1", empty); end
  endtask

  task automatic test_addr_err();
    set_src(1, 8'h20, 32'h55);
    src_wr_valid = 2'b10;
    #1;
    checks++; if (src_wr_rdy !== 2'b10) begin errors++; $display("FAIL err_rdy got %b exp 10", src_wr_rdy); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_pre got %b exp 0", addr_err); end
    tick();
    src_wr_valid = 2'b00;
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", addr_err); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL err_occ got %0d exp 0", occupancy); end
    // limit itself is illegal; a new error beats a simultaneous clear
    set_src(0, 8'h10, 32'h66);
    src_wr_valid = 2'b01;
    err_clr = 1'b1;
    tick();
    src_wr_valid = 2'b00;
    #1;
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", addr_err); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL err_limit_occ got %0d exp 0", occupancy); end
    tick();
    err_clr = 1'b0;
    #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", addr_err); end
    set_src(0, 8'h0F, 32'h77);
    src_wr_valid = 2'b01;
    tick();
    src_wr_valid = 2'b00;
    #1;
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL err_legal_occ got %0d exp 1", occupancy); end
    checks++; if (dcr_wr_addr !== 8'h0F) begin errors++; $display("FAIL err_legal_addr got %h exp 0f", dcr_wr_addr); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_legal_flag got %b exp 0", addr_err); end
    dcr_wr_rdy = 1'b1;
    tick();
    dcr_wr_rdy = 1'b0;
  endtask

  task automatic test_flush();
    src_wr_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      set_src(0, 8'h0C, 32'h500 + i);
      tick();
    end
    #1;
    checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL flush_pre_occ got %0d exp 5", occupancy); end
    flush = 1'b1;
    dcr_wr_rdy = 1'b1;
    #1;
    checks++; if (src_wr_rdy !== 2'b00) begin errors++; $display("FAIL flush_rdy got %b exp 00", src_wr_rdy); end
    tick();
    flush = 1'b0;
    src_wr_valid = 2'b00;
    dcr_wr_rdy = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (dcr_wr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", dcr_wr_valid); end
  endtask

  task automatic test_reset_mid();
    set_src(1, 8'h30, 32'h88);
    src_wr_valid = 2'b10;
    tick();
    src_wr_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      set_src(0, 8'h0B, 32'h600 + i);
      tick();
    end
    src_wr_valid = 2'b00;
    dcr_wr_rdy = 1'b1;
    tick();
    #1;
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL rstmid_pre_occ got %0d exp 2", occupancy); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre_err got %b exp 1", addr_err); end
    rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty got %b exp 1", empty); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rstmid_occ got %0d exp 0", occupancy); end
    checks++; if (dcr_wr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", dcr_wr_valid); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b exp 0", addr_err); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b exp 0", full); end
    tick();
    rst = 1'b0;
    dcr_wr_rdy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_busy_hold();
    test_addr_err();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
